io_uart_tx: RTL

IO_UART_TX -- requirements
Module: io_uart_tx

---
 rtl/io_uart_tx.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/io_uart_tx.sv
// UART transmitter with a small byte FIFO, toggle-handshake command port and sticky overflow.
// Optional even parity bit when IO_UART_TX_PARITY_EN is defined (11-bit frame, else 10-bit).
module io_uart_tx #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] cmd_in,
  input  logic [31:0] cfg_in,
  output logic [31:0] status_out,
  output logic        txd
);

  localparam int         PTR_W    = $clog2(FIFO_DEPTH);
  localparam logic [2:0] FULL_CNT = 3'(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

  logic             live_q, live_d;
  logic             tog_q, tog_d;
  logic             ovf_q, ovf_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [7:0]       mem [FIFO_DEPTH];

  state_e      state_q;
  logic [15:0] baud_q, div_q;
  logic [2:0]  bit_q;
  logic [7:0]  sh_q;
  logic        txd_q;
`ifdef IO_UART_TX_PARITY_EN
  logic        par_q;
`endif

  logic       req, push, pop, fifo_empty, fifo_full, bit_done;
  logic [7:0] head;
  logic       unused_bits;

  assign unused_bits = ^{cfg_in[31:16], cmd_in[29:8]};

  // The first edge after reset only arms the toggle detector.
  assign req        = live_q && (cmd_in[31] != tog_q);
  assign fifo_empty = (cnt_q == 3'd0);
  assign fifo_full  = (cnt_q == FULL_CNT);
  assign bit_done   = (baud_q == div_q);
  assign pop        = !fifo_empty && ((state_q == IDLE) || ((state_q == STOP) && bit_done));
  assign push       = req && !cmd_in[30] && (!fifo_full || pop);
  assign head       = mem[rd_ptr_q];

  always_comb begin
    live_d   = 1'b1;
    tog_d    = cmd_in[31];
    ovf_d    = ovf_q;
    if (req) begin
      if (cmd_in[30])  ovf_d = 1'b0;
      else if (!push)  ovf_d = 1'b1;
    end
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    cnt_d    = cnt_q + 3'(push) - 3'(pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      live_q   <= 1'b0;
      tog_q    <= 1'b0;
      ovf_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      live_q   <= live_d;
      tog_q    <= tog_d;
      ovf_q    <= ovf_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset: the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= cmd_in[7:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      baud_q  <= '0;
      div_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      txd_q   <= 1'b1;
`ifdef IO_UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else if (pop) begin
      // Pop from IDLE or straight out of the stop bit: start a new frame.
      state_q <= START;
      baud_q  <= '0;
      div_q   <= cfg_in[15:0];
      bit_q   <= '0;
      sh_q    <= head;
      txd_q   <= 1'b0;
`ifdef IO_UART_TX_PARITY_EN
      par_q   <= ^head;
`endif
    end else begin
      baud_q <= bit_done ? '0 : baud_q + 16'd1;
      case (state_q)
        IDLE: begin
          baud_q <= '0;
          txd_q  <= 1'b1;
        end
        START: if (bit_done) begin
          state_q <= DATA;
          txd_q   <= sh_q[0];
          sh_q    <= sh_q >> 1;
        end
        DATA: if (bit_done) begin
          if (bit_q == 3'd7) begin
`ifdef IO_UART_TX_PARITY_EN
            state_q <= PARITY;
            txd_q   <= par_q;
`else
            state_q <= STOP;
            txd_q   <= 1'b1;
`endif
          end else begin
            bit_q <= bit_q + 3'd1;
            txd_q <= sh_q[0];
            sh_q  <= sh_q >> 1;
          end
        end
        PARITY: if (bit_done) begin
          state_q <= STOP;
          txd_q   <= 1'b1;
        end
        STOP: if (bit_done) state_q <= IDLE;
        default: begin
          state_q <= IDLE;
          txd_q   <= 1'b1;
        end
      endcase
    end
  end

  assign txd        = txd_q;
  assign status_out = {tog_q, 24'h0, cnt_q, ovf_q, fifo_empty, fifo_full, (state_q != IDLE)};

endmodule
